// File: rtl/rb.sv
`default_nettype none
// ============================================================================
// Module      : rb
// Description : Read-back block. On start, reads four consecutive RAM words
//               at a fixed read latency and presents their low 18 bits in
//               parallel on LD1..LD4 with a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rb #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  base_addr,
  output logic        ram_en,
  output logic [7:0]  address,
  input  logic [31:0] dataRAM,
  output logic [17:0] LD1,
  output logic [17:0] LD2,
  output logic [17:0] LD3,
  output logic [17:0] LD4,
  output logic        valid,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [7:0]        base_q, base_d;
  logic [1:0]        iss_cnt_q, iss_cnt_d;
  logic [1:0]        ret_cnt_q, ret_cnt_d;
  logic [RD_LAT-1:0] flag_q, flag_d;
  logic [3:0][17:0]  slot_q, slot_d;
  logic [17:0]       ld1_q, ld1_d, ld2_q, ld2_d, ld3_q, ld3_d, ld4_q, ld4_d;
  logic              ram_en_q, ram_en_d;
  logic [7:0]        address_q, address_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              capture;
  logic              unused_hi;

  // Upper data bits are deliberately dropped.
  assign unused_hi = ^dataRAM[31:18];

  // Next-state, return capture and registered-output computation.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    iss_cnt_d = iss_cnt_q;
    ret_cnt_d = ret_cnt_q;
    slot_d    = slot_q;
    ld1_d     = ld1_q;
    ld2_d     = ld2_q;
    ld3_d     = ld3_q;
    ld4_d     = ld4_q;

    // The flag pipeline follows ram_en so its last stage is high exactly
    // in the cycles where dataRAM carries a requested word.
    flag_d[0] = ram_en_q;
    for (int i = 1; i < RD_LAT; i++) begin
      flag_d[i] = flag_q[i-1];
    end
    capture = flag_q[RD_LAT-1];

    if (capture) begin
      slot_d[ret_cnt_q] = dataRAM[17:0];
      ret_cnt_d         = ret_cnt_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          base_d    = base_addr;
          iss_cnt_d = 2'd0;
        end
      end
      S_ISSUE: begin
        iss_cnt_d = iss_cnt_q + 2'd1;
        if (iss_cnt_q == 2'd3) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last word is taken straight from the bus so the lanes are
        // visible in the DONE cycle itself.
        if (capture && (ret_cnt_q == 2'd3)) begin
          state_d = S_DONE;
          ld1_d   = slot_q[0];
          ld2_d   = slot_q[1];
          ld3_d   = slot_q[2];
          ld4_d   = dataRAM[17:0];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ram_en_d  = (state_d == S_ISSUE);
    address_d = ram_en_d ? (base_d + {6'd0, iss_cnt_d}) : 8'd0;
    valid_d   = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= 8'd0;
      iss_cnt_q <= 2'd0;
      ret_cnt_q <= 2'd0;
      flag_q    <= '0;
      slot_q    <= '0;
      ld1_q     <= 18'd0;
      ld2_q     <= 18'd0;
      ld3_q     <= 18'd0;
      ld4_q     <= 18'd0;
      ram_en_q  <= 1'b0;
      address_q <= 8'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      iss_cnt_q <= iss_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      flag_q    <= flag_d;
      slot_q    <= slot_d;
      ld1_q     <= ld1_d;
      ld2_q     <= ld2_d;
      ld3_q     <= ld3_d;
      ld4_q     <= ld4_d;
      ram_en_q  <= ram_en_d;
      address_q <= address_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign ram_en  = ram_en_q;
  assign address = address_q;
  assign LD1     = ld1_q;
  assign LD2     = ld2_q;
  assign LD3     = ld3_q;
  assign LD4     = ld4_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rb
// Description : Directed self-checking bench for rb at RD_LAT=1 and RD_LAT=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start1, start3;
  logic [7:0]  base1, base3;
  logic        en1, en3;
  logic [7:0]  addr1, addr3;
  logic [31:0] data1, data3;
  logic [17:0] l1_1, l2_1, l3_1, l4_1, l1_3, l2_3, l3_3, l4_3;
  logic        valid1, valid3, busy1, busy3;

  logic [31:0] mem [256];

  rb #(.RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base1),
    .ram_en(en1), .address(addr1), .dataRAM(data1),
    .LD1(l1_1), .LD2(l2_1), .LD3(l3_1), .LD4(l4_1),
    .valid(valid1), .busy(busy1)
  );

  rb #(.RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .base_addr(base3),
    .ram_en(en3), .address(addr3), .dataRAM(data3),
    .LD1(l1_3), .LD2(l2_3), .LD3(l3_3), .LD4(l4_3),
    .valid(valid3), .busy(busy3)
  );

  // RAM models: address seen in cycle k returns data in cycle k+latency.
  logic [7:0] ap1;
  logic [7:0] ap3 [3];
  always @(posedge clk) begin
    ap1    <= addr1;
    ap3[0] <= addr3;
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
  end
  assign data1 = mem[ap1];
  assign data3 = mem[ap3[2]];

  // Observation mux so one checking routine serves both instances.
  logic        sel3;
  logic        en_s, valid_s, busy_s;
  logic [7:0]  addr_s;
  logic [17:0] ld_s [4];
  always_comb begin
    en_s     = sel3 ? en3    : en1;
    addr_s   = sel3 ? addr3  : addr1;
    valid_s  = sel3 ? valid3 : valid1;
    busy_s   = sel3 ? busy3  : busy1;
    ld_s[0]  = sel3 ? l1_3   : l1_1;
    ld_s[1]  = sel3 ? l2_3   : l2_1;
    ld_s[2]  = sel3 ? l3_3   : l3_1;
    ld_s[3]  = sel3 ? l4_3   : l4_1;
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lanes(input string tag, input logic [17:0] e1, input logic [17:0] e2,
                           input logic [17:0] e3, input logic [17:0] e4);
    chk({tag, "_LD1"}, 32'(ld_s[0]), 32'(e1));
    chk({tag, "_LD2"}, 32'(ld_s[1]), 32'(e2));
    chk({tag, "_LD3"}, 32'(ld_s[2]), 32'(e3));
    chk({tag, "_LD4"}, 32'(ld_s[3]), 32'(e4));
  endtask

  // Caller is in cycle 0; start is driven here and sampled at its end.
  task automatic run_fetch(input bit l3, input logic [7:0] b, input bit hold,
                           input logic [17:0] e1, input logic [17:0] e2,
                           input logic [17:0] e3, input logic [17:0] e4);
    int lat;
    logic [7:0] ea;
    lat  = l3 ? 3 : 1;
    sel3 = l3;
    if (l3) begin start3 = 1'b1; base3 = b; end
    else    begin start1 = 1'b1; base1 = b; end
    for (int c = 1; c <= 6 + lat; c++) begin
      step();
      if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
      ea = (c <= 4) ? b + 8'(c - 1) : 8'd0;
      chk("ram_en",  32'(en_s),    32'(c <= 4));
      chk("address", 32'(addr_s),  32'(ea));
      chk("valid",   32'(valid_s), 32'(c == 5 + lat));
      chk("busy",    32'(busy_s),  32'(c <= 5 + lat));
      if (c >= 5 + lat) chk_lanes("lanes", e1, e2, e3, e4);
    end
    if (hold) begin
      step();
      chk("held_ram_en",  32'(en_s),   32'd1);
      chk("held_address", 32'(addr_s), 32'(b));
      start1 = 1'b0;
      start3 = 1'b0;
      for (int i = 0; i < 12; i++) step();
      chk("held_idle_busy", 32'(busy_s), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | 32'(i);
    mem[8'h10] = 32'h00000011;
    mem[8'h11] = 32'h00000022;
    mem[8'h12] = 32'h00000033;
    mem[8'h13] = 32'h0003FFFF;
    mem[8'hFE] = 32'hFFFC0005;
    mem[8'hFF] = 32'h12340067;
    mem[8'h00] = 32'h00000100;
    mem[8'h01] = 32'hFFFFFFFF;
    mem[8'h20] = 32'h0000000A;
    mem[8'h21] = 32'h0001000B;
    mem[8'h22] = 32'h0002000C;
    mem[8'h23] = 32'h0003000D;

    sel3   = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
    base1  = 8'd0; base3  = 8'd0;
    rst    = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    for (int s = 0; s < 2; s++) begin
      sel3 = (s == 1);
      chk("rst_ram_en",  32'(en_s),    32'd0);
      chk("rst_address", 32'(addr_s),  32'd0);
      chk("rst_valid",   32'(valid_s), 32'd0);
      chk("rst_busy",    32'(busy_s),  32'd0);
      chk_lanes("rst", 18'd0, 18'd0, 18'd0, 18'd0);
    end

    // Single fetch, RD_LAT=1.
    run_fetch(1'b0, 8'h10, 1'b0, 18'h00011, 18'h00022, 18'h00033, 18'h3FFFF);
    // Upper-bit masking and address wrap.
    run_fetch(1'b0, 8'hFE, 1'b0, 18'h00005, 18'h00067, 18'h00100, 18'h3FFFF);
    // start held high across a whole fetch.
    run_fetch(1'b0, 8'h10, 1'b1, 18'h00011, 18'h00022, 18'h00033, 18'h3FFFF);

    // Reset asserted in cycle 3 of a fetch.
    sel3   = 1'b0;
    start1 = 1'b1;
    base1  = 8'h10;
    step();
    start1 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ram_en", 32'(en_s),   32'd0);
    chk("midrst_busy",   32'(busy_s), 32'd0);
    chk_lanes("midrst", 18'd0, 18'd0, 18'd0, 18'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("midrst_no_valid", 32'(valid_s), 32'd0);
      chk("midrst_no_en",    32'(en_s),    32'd0);
    end
    run_fetch(1'b0, 8'h10, 1'b0, 18'h00011, 18'h00022, 18'h00033, 18'h3FFFF);

    // RD_LAT=3 instance.
    run_fetch(1'b1, 8'h20, 1'b0, 18'h0000A, 18'h1000B, 18'h2000C, 18'h3000D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rb.md
# rb

Read-back block, the counterpart of the write-back stage. On a start request it reads four consecutive words from the result RAM and unpacks their low 18 bits into four parallel lanes, LD1..LD4. It asserts a one-cycle valid when all four lanes are updated together. It sits between the shared result RAM port and any consumer that needs a stored 4-lane result group returned in parallel form.

## Interface
- RD_LAT, 1, RAM read latency in cycles from the address cycle to the data cycle; legal values are 1..3.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  fetch request; sampled only in IDLE.
- base_addr  in  8  address of the first word; latched when start is accepted.
- ram_en  out  1  RAM read enable; high only in cycles that issue an address.
- address  out  8  RAM read address; meaningful only while ram_en=1, otherwise 0.
- dataRAM  in  32  RAM read data; bits [31:18] are ignored.
- LD1, LD2, LD3, LD4  out  18 each  words read from base, base+1, base+2, base+3.
- valid  out  1  one-cycle pulse; LD1..LD4 change only in the cycle valid is high.
- busy  out  1  high from the first issue cycle through the valid cycle inclusive.

## Operation
- State machine states: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE when start=1. base_addr is latched at that edge.
- ISSUE lasts exactly 4 cycles, driven by a 2-bit issue counter running 0..3.
  - In each ISSUE cycle: ram_en=1 and address = base + counter (mod 256).
  - ISSUE -> DRAIN after the cycle with counter=3.
- Return tracking:
  - An RD_LAT-deep shift register of issue flags marks the cycles in which dataRAM carries a requested word.
  - Each flagged cycle captures dataRAM[17:0] into internal buffer slot k (k = 0..3, from a 2-bit return counter).
- DRAIN -> DONE at the edge that captures slot 3.
- In DONE:
  - LD1..LD4 are loaded from slots 0..3 together.
  - valid=1 for that one cycle.
  - DONE -> IDLE unconditionally.
- start is ignored whenever busy=1, including in the DONE cycle. A start held high in IDLE is accepted on the first IDLE cycle.
- Address arithmetic is 8-bit with wrap-around: base 0xFE issues 0xFE, 0xFF, 0x00, 0x01.
- Data is passed through raw: no sign extension and no arithmetic. Bits [31:18] of dataRAM never reach the outputs.
- LD1..LD4 hold their values between valid pulses.
- Reset values: state IDLE; ram_en=0, address=0, valid=0, busy=0; LD1..LD4=0; internal buffers, counters and flags=0.
- Reset mid-operation, in any state: the block returns to IDLE at that edge. In-flight returns are discarded, no valid is produced, and LD1..LD4 are cleared.

## Timing
- Reference point: start is sampled high in IDLE in cycle 0.
- All outputs are registered.
- Issue: ram_en=1 in cycles 1..4, with address = base..base+3.
- Data for the word issued in cycle k is present on dataRAM during cycle k+RD_LAT and is captured at the end of that cycle.
- valid=1 in cycle 5+RD_LAT; with RD_LAT=1, valid is in cycle 6.
- busy is high in cycles 1..5+RD_LAT.
- Back-to-back fetches: the earliest next accepted start is in cycle 6+RD_LAT, giving a new ram_en in cycle 7+RD_LAT.
- The block never issues more than 4 reads per accepted start. There is no stall input; the RAM must return data at the fixed RD_LAT.

## Test plan
- Reset: assert rst for 2 cycles -> ram_en=0, address=0, valid=0, busy=0, LD1..LD4=0 in the cycle after reset deasserts.
- Single fetch (RD_LAT=1): RAM[0x10..0x13] = 0x00011, 0x00022, 0x00033, 0x3FFFF; start with base 0x10 -> ram_en in cycles 1..4 with addresses 0x10..0x13; valid only in cycle 6 with LD1=0x00011, LD2=0x00022, LD3=0x00033, LD4=0x3FFFF.
- Upper-bit masking and wrap: RAM[0xFE]=0xFFFC0005, base 0xFE -> addresses 0xFE, 0xFF, 0x00, 0x01; LD1=0x00005.
- start held high through a whole fetch -> only one group of 4 reads is issued while busy; the second fetch's first ram_en appears in cycle 8 (RD_LAT=1).
- Reset in cycle 3 of ISSUE -> ram_en=0 in cycle 4; no valid pulse; LD1..LD4=0; the next start behaves exactly as from power-up.
- RD_LAT=3 -> valid in cycle 8; busy high in cycles 1..8; lane order matches issue order.
